// File: rtl/lsu_mmio.sv
// Load-store unit for the single-cycle RV32I core.
// Holds the data memory, the red/green LED output registers and a
// two-stage synchronised switch input port. Loads are combinational.
// Stores commit on the rising clock edge.
module lsu_mmio #(
  parameter int DMEM_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic        i_w_b,
  input  logic        i_l_unsigned,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic        o_misaligned
);

  localparam int AW = $clog2(DMEM_WORDS);

  // Peripheral registers are decoded on the word address, so byte
  // accesses to any lane of a register still hit that register.
  localparam logic [29:0] LEDR_WADDR = 30'h0400_0000;
  localparam logic [29:0] LEDG_WADDR = 30'h0400_0400;
  localparam logic [29:0] SW_WADDR   = 30'h0400_4000;

  logic [31:0] mem_q [DMEM_WORDS];
  logic [31:0] ledr_q, ledr_d;
  logic [31:0] ledg_q, ledg_d;
  logic [31:0] sw_meta_q, sw_sync_q;

  logic [29:0] wordAddr;
  logic [1:0]  lane;
  logic        hitDmem, hitLedr, hitLedg, hitSw;
  logic        misaligned;
  logic        storeEn;
  logic [3:0]  byteEn;
  logic [31:0] wrData;
  logic [31:0] rawWord;
  logic [7:0]  laneByte;
  logic [31:0] ldData;

  assign wordAddr = i_lsu_addr[31:2];
  assign lane     = i_lsu_addr[1:0];

  // The whole 32-bit address is decoded, so no region aliases another.
  assign hitDmem = (i_lsu_addr[31:AW+2] == '0);
  assign hitLedr = (wordAddr == LEDR_WADDR);
  assign hitLedg = (wordAddr == LEDG_WADDR);
  assign hitSw   = (wordAddr == SW_WADDR);

  assign misaligned = (i_lsu_wren | i_lsu_rden) & ~i_w_b & (lane != 2'b00);

  // A misaligned word store is dropped entirely.
  assign storeEn = i_lsu_wren & ~misaligned;
  assign byteEn  = i_w_b ? (4'b0001 << lane) : 4'b1111;
  assign wrData  = i_w_b ? {4{i_st_data[7:0]}} : i_st_data;

  // Replaces only the byte lanes selected by the enable mask.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = newWord[8*b +: 8];
    end
    return res;
  endfunction

  // Next-state values for the LED registers on a store that hits them.
  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    if (storeEn && hitLedr) ledr_d = mergeBytes(ledr_q, wrData, byteEn);
    if (storeEn && hitLedg) ledg_d = mergeBytes(ledg_q, wrData, byteEn);
  end

  // LED registers and switch synchroniser. Reset has priority over stores.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ledr_q    <= '0;
      ledg_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Data memory write port. Contents survive reset; only the store is blocked.
  always_ff @(posedge i_clk) begin
    if (!i_rst && storeEn && hitDmem) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem_q[i_lsu_addr[AW+1:2]][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  // Load path: pick the source word, then the lane and extension for bytes.
  always_comb begin
    rawWord = '0;
    if (hitDmem)      rawWord = mem_q[i_lsu_addr[AW+1:2]];
    else if (hitLedr) rawWord = ledr_q;
    else if (hitLedg) rawWord = ledg_q;
    else if (hitSw)   rawWord = sw_sync_q;

    case (lane)
      2'd0:    laneByte = rawWord[7:0];
      2'd1:    laneByte = rawWord[15:8];
      2'd2:    laneByte = rawWord[23:16];
      default: laneByte = rawWord[31:24];
    endcase

    ldData = '0;
    if (i_lsu_rden && !misaligned) begin
      if (i_w_b) begin
        ldData = i_l_unsigned ? {24'h0, laneByte} : {{24{laneByte[7]}}, laneByte};
      end else begin
        ldData = rawWord;
      end
    end
  end

  assign o_ld_data    = ldData;
  assign o_misaligned = misaligned;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;

endmodule
